// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Frame length depends on the UART_TX_PARITY_EN build macro (see uart_tx_completa).
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int FRAME_BITS_PAR   = 11;
  localparam int FRAME_BITS_NOPAR = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/baud_counter_tx.sv
// Bit-period counter for the UART transmitter.
// It is held at zero while disabled and pulses tick on its terminal count.
module baud_counter_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;

  // Terminal count is only meaningful while the transmitter is active.
  always_comb begin
    tick_s = 1'b0;
    if (enable && (cnt_r == LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Counter state: cleared when disabled, wraps on terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!enable) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/uart_tx_completa.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN for the 11-bit frame; leave it undefined for 10-bit frames.
module uart_tx_completa
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] d,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  tx_state_t         state_r;
  tx_state_t         state_nx_s;
  logic [2:0]        bit_idx_r;
  logic [2:0]        bit_idx_nx_s;
  logic [DATA_W-1:0] data_r;
  logic              tx_r;
  logic              tx_nx_s;
  logic              busy_r;
  logic              done_r;
  logic              tick_s;
  logic              baud_en_s;
`ifdef UART_TX_PARITY_EN
  logic              par_r;
`endif

  assign baud_en_s = (state_r != IDLE);

  baud_counter_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .enable(baud_en_s),
    .tick  (tick_s)
  );

  // Next-state and bit-index logic; every bit period ends on a baud tick.
  always_comb begin
    state_nx_s   = state_r;
    bit_idx_nx_s = bit_idx_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = START;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_nx_s   = DATA;
          bit_idx_nx_s = 3'd0;
        end else begin
          state_nx_s = START;
        end
      end
      DATA: begin
        if (tick_s && (bit_idx_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_nx_s = PARITY;
`else
          state_nx_s = STOP;
`endif
        end else if (tick_s) begin
          bit_idx_nx_s = bit_idx_r + 3'd1;
        end else begin
          state_nx_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          state_nx_s = STOP;
        end else begin
          state_nx_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = STOP;
        end
      end
      default: begin
        state_nx_s   = IDLE;
        bit_idx_nx_s = 3'd0;
      end
    endcase
  end

  // Line level for the current state; registered one cycle later into tx_r.
  always_comb begin
    tx_nx_s = 1'b1;
    case (state_r)
      IDLE:    tx_nx_s = 1'b1;
      START:   tx_nx_s = 1'b0;
      DATA:    tx_nx_s = data_r[bit_idx_r];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nx_s = par_r;
`endif
      STOP:    tx_nx_s = 1'b1;
      default: tx_nx_s = 1'b1;
    endcase
  end

  // State, data latch and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      bit_idx_r <= 3'd0;
      data_r    <= {DATA_W{1'b0}};
`ifdef UART_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      bit_idx_r <= bit_idx_nx_s;
      if ((state_r == IDLE) && start) begin
        data_r <= d;
`ifdef UART_TX_PARITY_EN
        par_r  <= even_parity(d);
`endif
      end
      tx_r   <= tx_nx_s;
      busy_r <= (state_r != IDLE);
      done_r <= (state_r == STOP) && tick_s;
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_tx_completa.sv
// Self-checking bench for uart_tx_completa with CLKS_PER_BIT=4.
// A frame-timeline model is compared every cycle; directed tests pin literal frames.
module tb_uart_tx_completa;
  import uart_pkg::*;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = FRAME_BITS_PAR;
`else
  localparam int FB = FRAME_BITS_NOPAR;
`endif
  localparam int L = FB * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] d = 8'h00;
  logic       tx;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  uart_tx_completa #(.CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .d    (d),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame built from the line format: start 0, data LSB first, even parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    f = 11'h7FF;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = b[i];
      ones += int'(b[i]);
    end
`ifdef UART_TX_PARITY_EN
    f[9] = ((ones % 2) == 1) ? 1'b1 : 1'b0;
`endif
    return f;
  endfunction

  // Model: pos = edges since the accepting edge, -1 when idle after reset.
  int          pos = -1;
  logic [10:0] mbits = 11'h7FF;

  always @(posedge clk) begin
    if (reset) begin
      pos = -1;
    end else if ((pos < 0 || pos >= L) && start) begin
      pos   = 0;
      mbits = frame_of(d);
    end else if (pos >= 0 && pos <= L) begin
      pos = pos + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (pos >= 1 && pos <= L) begin
        check("tx_model", {31'd0, tx}, {31'd0, mbits[(pos-1)/C]});
        check("busy_model", {31'd0, busy}, 32'd1);
        check("done_model", {31'd0, done}, (pos == L) ? 32'd1 : 32'd0);
      end else begin
        check("tx_model", {31'd0, tx}, 32'd1);
        check("busy_model", {31'd0, busy}, 32'd0);
        check("done_model", {31'd0, done}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    d = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    d = 8'h00;
  endtask

  // Samples mid-bit levels after an accepted request; optionally pokes start mid-frame.
  task automatic capture(input int poke_at, output logic [10:0] cap, output int done_at,
                         output int busy_n, output int done_n);
    cap = 11'h7FF;
    done_at = -1;
    busy_n = 0;
    done_n = 0;
    for (int j = 1; j <= L + 3; j++) begin
      if (j == poke_at) begin
        start = 1'b1;
        d = 8'hFF;
      end else if (j == poke_at + 1) begin
        start = 1'b0;
        d = 8'h00;
      end
      tick();
      if (j <= L && ((j - 1) % C) == C / 2) cap[(j-1)/C] = tx;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = j;
      end
    end
  endtask

  logic [10:0] cap;
  logic [10:0] lit;
  logic [7:0]  q;
  int          done_at, busy_n, done_n;

  initial begin
    // Reset held for three cycles
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_tx", {31'd0, tx}, 32'd1);
    end

`ifdef UART_TX_PARITY_EN
    // Single byte 0xA5
    send(8'hA5);
    capture(-5, cap, done_at, busy_n, done_n);
    lit = 11'h54A;
    check("a5_frame", {21'd0, cap}, {21'd0, lit});
    check("a5_done_cycle", done_at, 32'd44);
    check("a5_busy_cycles", busy_n, 32'd44);
    check("a5_done_count", done_n, 32'd1);
    lit = frame_of(8'hA5);
    check("model_a5", {21'd0, lit}, 32'h54A);

    // Odd-parity byte 0x07 decoded as a receiver would
    send(8'h07);
    capture(-5, cap, done_at, busy_n, done_n);
    q = cap[8:1];
    check("rx_q_07", {24'd0, q}, 32'h07);
    check("rx_paridad_07", {31'd0, cap[9]}, 32'd1);
    check("rx_stop_07", {31'd0, cap[10]}, 32'd1);
    lit = frame_of(8'h07);
    check("model_par_07", {31'd0, lit[9]}, 32'd1);
`else
    // No-parity byte 0x55
    send(8'h55);
    capture(-5, cap, done_at, busy_n, done_n);
    lit = cap;
    check("55_frame", {22'd0, lit[9:0]}, 32'h2AA);
    check("55_done_cycle", done_at, 32'd40);
    check("55_busy_cycles", busy_n, 32'd40);
    send(8'h07);
    capture(-5, cap, done_at, busy_n, done_n);
    q = cap[8:1];
    check("rx_q_07", {24'd0, q}, 32'h07);
`endif

    // Request while busy is ignored
    send(8'h3C);
    capture(20, cap, done_at, busy_n, done_n);
    q = cap[8:1];
    check("busy_ignore_q", {24'd0, q}, 32'h3C);
    check("busy_ignore_dones", done_n, 32'd1);
`ifdef UART_TX_PARITY_EN
    check("busy_ignore_par", {31'd0, cap[9]}, 32'd0);
`endif
    repeat (6) tick();

    // Reset during data bit 3
    send(8'hC3);
    repeat (18) tick();
    reset = 1'b1;
    tick();
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    done_n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done) done_n++;
    end
    check("midreset_no_done", done_n, 32'd0);
    send(8'h81);
    capture(-5, cap, done_at, busy_n, done_n);
    q = cap[8:1];
    check("after_reset_q", {24'd0, q}, 32'h81);
    check("after_reset_done", done_at, L);
`ifdef UART_TX_PARITY_EN
    check("after_reset_par", {31'd0, cap[9]}, 32'd0);
`endif

    // start and reset together: reset wins
    reset = 1'b1;
    start = 1'b1;
    d = 8'hAA;
    tick();
    reset = 1'b0;
    start = 1'b0;
    d = 8'h00;
    tick();
    check("reset_wins_busy", {31'd0, busy}, 32'd0);
    repeat (4) tick();

    // Back-to-back frames with start held high
    d = 8'h5A;
    start = 1'b1;
    tick();
    done_n = 0;
    for (int j = 1; j <= 2 * L + 1; j++) begin
      tick();
      if (done) done_n++;
    end
    start = 1'b0;
    d = 8'h00;
    check("b2b_dones", done_n, 32'd2);
    repeat (L + 6) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
